oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 160 ++++++++++++++++
 tb/tb_oam_dma.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma -- sprite attribute (OAM) DMA engine.
//
// A CPU write to DMA_REG_ADDR latches a source page and copies XFER_LEN bytes
// from {page,8'h00} onwards into OAM starting at OAM_BASE. Each byte is copied
// as a read request followed by a write request on a simple req/ack master bus.
//
// Master bus handshake: m_req is high while a request is outstanding. m_addr,
// m_we and m_wdata are held stable until the cycle in which m_ack is sampled
// high; that edge completes the request. For reads, m_rdata is sampled on that
// same edge. Wait states are unlimited.
//
// Optional feature: define OAM_DMA_CPU_BLOCK_EN to raise cpu_stall for CPU
// accesses outside high RAM (FF80-FFFE) and the DMA register while busy. With
// the macro undefined cpu_stall is tied low.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cpu_addr/cpu_wdata    CPU access address / write data
//   cpu_we/cpu_re         single-cycle CPU write / read strobes
//   cpu_rdata/cpu_rvalid  registered read response (next cycle)
//   m_req/m_we/m_addr/m_wdata  master request (registered)
//   m_rdata/m_ack         master read data / request completion
//   busy                  transfer in progress (RD or WR)
//   done                  one-cycle pulse after the final byte is written
//   cpu_stall             CPU access-blocked indication
//   dbg_state             current FSM state (0 idle, 1 read, 2 write)
// -----------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          XFER_LEN     = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    output logic        m_req,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic [7:0]  m_rdata,
    input  logic        m_ack,
    output logic        busy,
    output logic        done,
    output logic        cpu_stall,
    output logic [1:0]  dbg_state
);

    localparam int IW = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(XFER_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    src;
    logic [7:0]    page;
    logic [IW-1:0] idx;

    logic          reg_hit;
    logic          start;
    logic [7:0]    start_page;
    logic [IW-1:0] idx_next;

    assign reg_hit  = (cpu_addr == DMA_REG_ADDR);
    assign start    = cpu_we && reg_hit;
    assign idx_next = idx + IW'(1);

    // Echo RAM (E000-FDFF) aliases work RAM 0x2000 lower, so pages E0 and up
    // are folded down before use.
    assign start_page = (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src        <= 8'h00;
            page       <= 8'h00;
            idx        <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= 16'h0000;
            m_wdata    <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= 8'h00;
        end else begin
            done       <= 1'b0;
            cpu_rvalid <= cpu_re && reg_hit;
            cpu_rdata  <= (cpu_re && reg_hit) ? src : 8'h00;

            if (start) begin
                // A start (or restart) wins over any ack this cycle: the
                // outstanding request is dropped and byte 0 is read next.
                src    <= cpu_wdata;
                page   <= start_page;
                idx    <= '0;
                state  <= RD;
                m_req  <= 1'b1;
                m_we   <= 1'b0;
                m_addr <= {start_page, 8'h00};
                busy   <= 1'b1;
            end else begin
                case (state)
                    RD: begin
                        if (m_ack) begin
                            // m_wdata doubles as the byte holding register.
                            m_wdata <= m_rdata;
                            m_we    <= 1'b1;
                            m_addr  <= OAM_BASE + 16'(idx);
                            state   <= WR;
                        end
                    end
                    WR: begin
                        if (m_ack) begin
                            if (idx == LAST_IDX) begin
                                state <= IDLE;
                                idx   <= '0;
                                m_req <= 1'b0;
                                m_we  <= 1'b0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                idx    <= idx_next;
                                m_we   <= 1'b0;
                                m_addr <= {page, 8'h00} + 16'(idx_next);
                                state  <= RD;
                            end
                        end
                    end
                    default: begin
                        m_req <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef OAM_DMA_CPU_BLOCK_EN
    // High RAM and the DMA register stay reachable so code can run and
    // restart the transfer while the bus is owned by the DMA.
    assign cpu_stall = busy && (cpu_re || cpu_we)
                       && !((cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE))
                       && (cpu_addr != DMA_REG_ADDR);
`else
    assign cpu_stall = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma -- self-checking bench for oam_dma.
// A bus responder backs the master port with a 64 KiB byte memory and acks
// either every cycle or after a random 0-5 cycle delay. Expected bus traffic
// is generated from the copy rule (page echo fold, read source byte k, write
// OAM byte k) into a scoreboard queue. Register/stall behaviour is checked
// from a vector table; restart and reset corner cases are hand sequenced.
// -----------------------------------------------------------------------------
module tb_oam_dma;

    localparam logic [15:0] DMA_REG = 16'hFF46;
    localparam logic [15:0] OAM_B   = 16'hFE00;
    localparam int          LEN     = 160;

`ifdef OAM_DMA_CPU_BLOCK_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we, cpu_re;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        m_req, m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    logic        m_ack;
    logic        busy, done, cpu_stall;
    logic [1:0]  dbg_state;

    oam_dma #(
        .DMA_REG_ADDR(DMA_REG),
        .OAM_BASE    (OAM_B),
        .XFER_LEN    (LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .busy      (busy),
        .done      (done),
        .cpu_stall (cpu_stall),
        .dbg_state (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference memory and scoreboard ----------------
    logic [7:0]  mem [0:65535];
    logic [7:0]  oam_seen [0:LEN-1];
    logic [24:0] exp_q[$];          // {we, addr, data}; data is 0 for reads
    logic [7:0]  cur_page;

    task automatic load_exp(input logic [7:0] s);
        logic [15:0] ra;
        cur_page = (s >= 8'hE0) ? (s - 8'h20) : s;
        exp_q.delete();
        for (int k = 0; k < LEN; k++) begin
            ra = {cur_page, 8'h00} + 16'(k);
            exp_q.push_back({1'b0, ra, 8'h00});
            exp_q.push_back({1'b1, OAM_B + 16'(k), mem[ra]});
            oam_seen[k] = ~mem[ra];
        end
    endtask

    // ---------------- bus responder / monitor ----------------
    bit   ack_rand   = 1'b0;
    bit   ack_block  = 1'b0;
    bit   chk_stable = 1'b0;
    bit   tim_en     = 1'b0;
    int   tim_base   = 0;
    int   op_idx     = 0;
    int   wait_cnt   = 0;
    int   done_cnt   = 0;
    int   done_cyc   = -1;
    int   writes_done = 0;

    logic        prev_wait  = 1'b0;
    logic        prev_start = 1'b0;
    logic [15:0] prev_addr;
    logic        prev_we;
    logic [7:0]  prev_wdata;
    logic        start_now;
    logic [24:0] act_op, exp_op;
    int          oidx;

    initial begin
        m_ack   = 1'b0;
        m_rdata = 8'h00;
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end

        if (chk_stable && prev_wait && (m_req === 1'b1) && !prev_start) begin
            chk("hold_addr",  m_addr,  prev_addr);
            chk("hold_we",    m_we,    prev_we);
            chk("hold_wdata", m_wdata, prev_wdata);
        end

        // An ack in a start/reset cycle would be discarded, so none is given.
        start_now = ((cpu_we === 1'b1) && (cpu_addr == DMA_REG)) || (reset === 1'b1);

        if ((m_req === 1'b1) && !start_now && !ack_block && (!ack_rand || wait_cnt == 0)) begin
            m_ack   = 1'b1;
            m_rdata = mem[m_addr];
            act_op  = {m_we, m_addr, (m_we ? m_wdata : 8'h00)};
            if (exp_q.size() == 0) begin
                chk("bus_op_unexpected_qsize", exp_q.size(), 1);
            end else begin
                exp_op = exp_q.pop_front();
                chk("bus_op", act_op, exp_op);
            end
            if (tim_en) chk("op_cycle", cyc, tim_base + op_idx);
            op_idx++;
            if (m_we) begin
                oidx = int'(m_addr - OAM_B);
                if (oidx >= 0 && oidx < LEN) oam_seen[oidx] = m_wdata;
                writes_done++;
            end
            wait_cnt = ack_rand ? $urandom_range(0, 5) : 0;
        end else begin
            m_ack   = 1'b0;
            m_rdata = 8'($urandom);
            if ((m_req === 1'b1) && ack_rand && !ack_block && !start_now && wait_cnt > 0)
                wait_cnt--;
        end

        prev_wait  = (m_req === 1'b1) && !m_ack;
        prev_start = start_now;
        prev_addr  = m_addr;
        prev_we    = m_we;
        prev_wdata = m_wdata;
    end

    // ---------------- driver tasks (called at posedge + 2) ----------------
    int start_cyc = 0;

    task automatic start_xfer(input logic [7:0] s);
        load_exp(s);
        writes_done = 0;
        cpu_addr  = DMA_REG;
        cpu_wdata = s;
        cpu_we    = 1'b1;
        @(posedge clk); #2;
        cpu_we    = 1'b0;
        start_cyc = cyc;
        tim_base  = cyc;
        op_idx    = 0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int c = 0; c < budget && done_cnt < target; c++) begin
            @(posedge clk); #2;
        end
        chk("done_seen", done_cnt, target);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int c = 0; c < budget && writes_done < n; c++) begin
            @(posedge clk); #2;
        end
        chk("writes_reached", writes_done, n);
    endtask

    task automatic check_end(input int d_target);
        int mism;
        logic [15:0] ra;
        mism = 0;
        repeat (4) begin @(posedge clk); #2; end
        for (int k = 0; k < LEN; k++) begin
            ra = {cur_page, 8'h00} + 16'(k);
            if (oam_seen[k] !== mem[ra]) mism++;
        end
        chk("oam_contents_mismatches", mism, 0);
        chk("queue_left", exp_q.size(), 0);
        chk("busy_after", busy, 0);
        chk("single_done", done_cnt, d_target);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    // ---------------- register / stall vector table ----------------
    typedef struct {
        logic        re;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        exp_rvalid;
        logic [7:0]  exp_rdata;
        logic        blk;        // access would stall with blocking enabled
    } vec_t;

    vec_t vecs [11];

    // ---------------- main sequence ----------------
    int d0;
    logic [7:0] s;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'hFF46, 8'h00, 1'b1, 8'h12, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'hC000, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 16'hFF80, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'hFFFE, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 16'hFF7F, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 16'hC000, 8'h55, 1'b0, 8'h00, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 16'hFF46, 8'h34, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'hFF46, 8'h00, 1'b1, 8'h34, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'hC000, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'hFF47, 8'h00, 1'b0, 8'h00, 1'b1};

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

        cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_we = 1'b0; cpu_re = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        // Reset state
        chk("rst_m_req", m_req, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        reset = 1'b0;
        @(posedge clk); #2;

        // Idle read of the register and a stall probe while idle
        cpu_addr = 16'hC000; cpu_re = 1'b1;
        #1 chk("idle_stall", cpu_stall, 0);
        @(posedge clk); #2;
        chk("idle_other_rvalid", cpu_rvalid, 0);
        cpu_addr = DMA_REG;
        @(posedge clk); #2;
        cpu_re = 1'b0;
        chk("idle_reg_rvalid", cpu_rvalid, 1);
        chk("idle_reg_rdata", cpu_rdata, 0);

        // Back-to-back acks: exact cycle timing for page C1
        ack_rand = 1'b0; tim_en = 1'b1;
        d0 = done_cnt;
        start_xfer(8'hC1);
        chk("first_rd_req", m_req, 1);
        chk("first_rd_we", m_we, 0);
        chk("first_rd_addr", m_addr, 16'hC100);
        chk("first_busy", busy, 1);
        wait_done(d0 + 1, 400);
        chk("done_cycle", done_cyc, start_cyc + 2 * LEN);
        tim_en = 1'b0;
        check_end(d0 + 1);

        // Random wait states on random pages
        ack_rand = 1'b1; chk_stable = 1'b1;
        for (int r = 0; r < 2; r++) begin
            d0 = done_cnt;
            s = 8'($urandom);
            start_xfer(s);
            wait_done(d0 + 1, 3000);
            check_end(d0 + 1);
        end

        // Echo page FE folds to DE
        d0 = done_cnt;
        start_xfer(8'hFE);
        chk("echo_first_addr", m_addr, 16'hDE00);
        wait_done(d0 + 1, 3000);
        check_end(d0 + 1);
        chk_stable = 1'b0;

        // Restart with C2 once bytes 0..49 have been written
        ack_rand = 1'b0;
        d0 = done_cnt;
        start_xfer(8'hC1);
        wait_writes(50, 400);
        start_xfer(8'hC2);
        chk("restart_addr", m_addr, 16'hC200);
        chk("restart_we", m_we, 0);
        chk("restart_req", m_req, 1);
        chk("restart_no_done", done, 0);
        wait_done(d0 + 1, 400);
        check_end(d0 + 1);

        // Reset at byte 80
        d0 = done_cnt;
        s = 8'($urandom_range(0, 8'hDF));
        start_xfer(s);
        wait_writes(80, 400);
        do_reset();
        chk("midrst_m_req", m_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        repeat (5) begin @(posedge clk); #2; end
        chk("midrst_no_done", done_cnt, d0);
        cpu_addr = DMA_REG; cpu_re = 1'b1;
        @(posedge clk); #2;
        cpu_re = 1'b0;
        chk("midrst_reg_rvalid", cpu_rvalid, 1);
        chk("midrst_reg_rdata", cpu_rdata, 0);

        // Register/stall table while busy (bus never acks)
        ack_block = 1'b1;
        start_xfer(8'h12);
        for (int v = 0; v < 11; v++) begin
            cpu_re    = vecs[v].re;
            cpu_we    = vecs[v].we;
            cpu_addr  = vecs[v].addr;
            cpu_wdata = vecs[v].wdata;
            #1;
            chk($sformatf("vec%0d_stall", v), cpu_stall, vecs[v].blk & STALL_EN);
            chk($sformatf("vec%0d_busy", v), busy, 1);
            @(posedge clk); #2;
            chk($sformatf("vec%0d_rvalid", v), cpu_rvalid, vecs[v].exp_rvalid);
            chk($sformatf("vec%0d_rdata", v), cpu_rdata, vecs[v].exp_rdata);
        end
        cpu_re = 1'b0; cpu_we = 1'b0;
        do_reset();
        ack_block = 1'b0;
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
